// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, encodings, control bundle and FSM state type
package rv_ctrl_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_EBREAK = 5'b11100;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;

    localparam logic [1:0] WB_AUIPC   = 2'b00;
    localparam logic [1:0] WB_PC4     = 2'b01;
    localparam logic [1:0] WB_ALU     = 2'b10;
    localparam logic [1:0] WB_LUI     = 2'b11;

    localparam logic [1:0] JAL_NONE   = 2'b00;
    localparam logic [1:0] JAL_BRANCH = 2'b01;
    localparam logic [1:0] JAL_JALR   = 2'b10;
    localparam logic [1:0] JAL_JAL    = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_WAIT = 2'b01,
        ST_HALT    = 2'b10
    } state_t;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       jal_flag;
        logic [1:0] jal_sel;
        logic [1:0] wb_sel;
        logic       r_check;
        logic       md_op;
        logic [2:0] md_funct;
    } ctrl_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// rtl/rv_ctrl_decode.sv - combinational opcode decode into the control bundle
module rv_ctrl_decode
    import rv_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_0,
    output ctrl_t      ctrl,
    output logic       m_op,
    output logic       illegal,
    output logic       is_ebreak
);

    always_comb begin
        ctrl      = '0;
        illegal   = 1'b0;
        is_ebreak = 1'b0;
        m_op      = (ENABLE_M != 0) && (opcode == OPC_OP) && funct7_0;
        case (opcode)
            OPC_LOAD: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.wb_sel     = WB_ALU;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OPC_OP_IMM: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.wb_sel    = WB_ALU;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.r_check   = 1'b1;
                ctrl.alu_op    = ALU_RTYPE;
                ctrl.wb_sel    = WB_ALU;
                if (m_op) begin
                    ctrl.md_op    = 1'b1;
                    ctrl.md_funct = funct3;
                end
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_LUI;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_AUIPC;
            end
            OPC_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = ALU_BRANCH;
                ctrl.jal_sel = JAL_BRANCH;
            end
            OPC_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.jal_flag  = 1'b1;
                ctrl.jal_sel   = JAL_JALR;
                ctrl.wb_sel    = WB_PC4;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jal_flag  = 1'b1;
                ctrl.jal_sel   = JAL_JAL;
                ctrl.wb_sel    = WB_PC4;
            end
            OPC_FENCE: begin
                ctrl = '0;
            end
            OPC_EBREAK: begin
                is_ebreak = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_seq_control_unit.sv
// rtl/rv_seq_control_unit.sv - registered ID/EX control with M-op sequencing and halt
module rv_seq_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_0,
    input  logic       flush,
    input  logic       resume,
    output logic       ctrl_valid,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_write,
    output logic [1:0] alu_op,
    output logic       jal_flag,
    output logic [1:0] jal_sel,
    output logic [1:0] wb_sel,
    output logic       r_check,
    output logic       md_op,
    output logic [2:0] md_funct,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_abort,
    output logic       halted,
    output logic       illegal
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    ctrl_t            pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic             start_q, start_d;
    logic             abort_q, abort_d;

    ctrl_t            dec_ctrl;
    logic             dec_m_op;
    logic             dec_illegal;
    logic             dec_ebreak;
    logic             accept;
    logic [CNT_W-1:0] md_latency;

    rv_ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_0  (funct7_0),
        .ctrl      (dec_ctrl),
        .m_op      (dec_m_op),
        .illegal   (dec_illegal),
        .is_ebreak (dec_ebreak)
    );

    // Gated by rst_n so every output reads 0 while reset is held.
    assign instr_ready = rst_n && (state_q == ST_RUN) && !flush;
    assign accept      = instr_valid && instr_ready;
    assign md_latency  = funct3[2] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        pend_d    = pend_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (dec_m_op) begin
                        state_d = ST_MD_WAIT;
                        cnt_d   = md_latency;
                        pend_d  = dec_ctrl;
                        start_d = 1'b1;
                    end else begin
                        ctrl_d    = dec_ctrl;
                        valid_d   = 1'b1;
                        illegal_d = dec_illegal;
                        if (dec_ebreak) begin
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_MD_WAIT: begin
                if (flush) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    ctrl_d  = pend_q;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            pend_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
        end
    end

    assign ctrl_valid = valid_q;
    assign branch     = ctrl_q.branch;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign mem_write  = ctrl_q.mem_write;
    assign alu_src    = ctrl_q.alu_src;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_op     = ctrl_q.alu_op;
    assign jal_flag   = ctrl_q.jal_flag;
    assign jal_sel    = ctrl_q.jal_sel;
    assign wb_sel     = ctrl_q.wb_sel;
    assign r_check    = ctrl_q.r_check;
    assign md_op      = ctrl_q.md_op;
    assign md_funct   = ctrl_q.md_funct;
    assign md_start   = start_q;
    assign md_abort   = abort_q;
    assign md_busy    = (state_q == ST_MD_WAIT);
    assign halted     = (state_q == ST_HALT);
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_rv_seq_control_unit.sv
// tb/tb_rv_seq_control_unit.sv - scoreboard bench for rv_seq_control_unit
module tb_rv_seq_control_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic instr_valid = 1'b0, funct7_0 = 1'b0, flush = 1'b0, resume = 1'b0;
    logic [4:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic instr_ready, ctrl_valid, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic jal_flag, r_check, md_op, md_start, md_busy, md_abort, halted, illegal;
    logic [1:0] alu_op, jal_sel, wb_sel;
    logic [2:0] md_funct;

    logic n_instr_valid = 1'b0, n_funct7_0 = 1'b0;
    logic [4:0] n_opcode = '0;
    logic [2:0] n_funct3 = '0;
    logic n_instr_ready, n_ctrl_valid, n_branch, n_mem_read, n_mem_to_reg, n_mem_write, n_alu_src;
    logic n_reg_write, n_jal_flag, n_r_check, n_md_op, n_md_start, n_md_busy, n_md_abort, n_halted, n_illegal;
    logic [1:0] n_alu_op, n_jal_sel, n_wb_sel;
    logic [2:0] n_md_funct;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int m_busy = 0;
    bit m_halted = 1'b0;
    logic [18:0] m_pend = '0;
    int exp_cyc_q[$];
    logic [18:0] exp_b_q[$];
    int start_q[$];
    int abort_q[$];

    localparam int MULC = 2;
    localparam int DIVC = 32;

    rv_seq_control_unit #(.ENABLE_M(1), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct3(funct3), .funct7_0(funct7_0), .flush(flush), .resume(resume),
        .ctrl_valid(ctrl_valid), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
        .jal_flag(jal_flag), .jal_sel(jal_sel), .wb_sel(wb_sel), .r_check(r_check),
        .md_op(md_op), .md_funct(md_funct), .md_start(md_start), .md_busy(md_busy),
        .md_abort(md_abort), .halted(halted), .illegal(illegal)
    );

    rv_seq_control_unit #(.ENABLE_M(0), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut_nm (
        .clk(clk), .rst_n(rst_n), .instr_valid(n_instr_valid), .instr_ready(n_instr_ready),
        .opcode(n_opcode), .funct3(n_funct3), .funct7_0(n_funct7_0), .flush(1'b0), .resume(1'b0),
        .ctrl_valid(n_ctrl_valid), .branch(n_branch), .mem_read(n_mem_read), .mem_to_reg(n_mem_to_reg),
        .mem_write(n_mem_write), .alu_src(n_alu_src), .reg_write(n_reg_write), .alu_op(n_alu_op),
        .jal_flag(n_jal_flag), .jal_sel(n_jal_sel), .wb_sel(n_wb_sel), .r_check(n_r_check),
        .md_op(n_md_op), .md_funct(n_md_funct), .md_start(n_md_start), .md_busy(n_md_busy),
        .md_abort(n_md_abort), .halted(n_halted), .illegal(n_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [18:0] obs = {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op,
                       jal_flag, jal_sel, wb_sel, r_check, md_op, md_funct, illegal};
    wire [18:0] n_obs = {n_branch, n_mem_read, n_mem_to_reg, n_mem_write, n_alu_src, n_reg_write, n_alu_op,
                         n_jal_flag, n_jal_sel, n_wb_sel, n_r_check, n_md_op, n_md_funct, n_illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level decode table; packing order matches obs.
    function automatic logic [18:0] ref_decode(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                                               input bit m_en);
        logic br, mr, mtr, mw, as, rw, jf, rc, mo, il;
        logic [1:0] ao, js, ws;
        logic [2:0] mf;
        {br, mr, mtr, mw, as, rw, jf, rc, mo, il} = '0;
        ao = 2'b00; js = 2'b00; ws = 2'b00; mf = 3'b000;
        case (op)
            5'b00000: begin mr = 1; mtr = 1; as = 1; rw = 1; ws = 2'b10; end
            5'b01000: begin mw = 1; as = 1; end
            5'b00100: begin as = 1; rw = 1; ws = 2'b10; end
            5'b01100: begin
                rw = 1; rc = 1; ao = 2'b10; ws = 2'b10;
                if (f7 && m_en) begin mo = 1; mf = f3; end
            end
            5'b01101: begin rw = 1; ws = 2'b11; end
            5'b00101: begin rw = 1; ws = 2'b00; end
            5'b11000: begin br = 1; ao = 2'b01; js = 2'b01; end
            5'b11001: begin rw = 1; jf = 1; js = 2'b10; ws = 2'b01; end
            5'b11011: begin rw = 1; jf = 1; js = 2'b11; ws = 2'b01; end
            5'b00011, 5'b11100: begin end
            default: il = 1;
        endcase
        return {br, mr, mtr, mw, as, rw, ao, jf, js, ws, rc, mo, mf, il};
    endfunction

    // Transaction-level model: what each input cycle should cause one cycle later.
    task automatic model_step(input logic v, input logic [4:0] op, input logic [2:0] f3, input logic f7,
                              input logic fl, input logic rs);
        logic [18:0] b;
        if (m_halted) begin
            if (rs) m_halted = 1'b0;
        end else if (m_busy > 0) begin
            if (fl) begin
                m_busy = 0;
                abort_q.push_back(cyc + 1);
            end else if (m_busy == 1) begin
                m_busy = 0;
                exp_cyc_q.push_back(cyc + 1);
                exp_b_q.push_back(m_pend);
            end else begin
                m_busy--;
            end
        end else if (v && !fl) begin
            b = ref_decode(op, f3, f7, 1'b1);
            if (op == 5'b01100 && f7) begin
                m_busy = f3[2] ? DIVC : MULC;
                m_pend = b;
                start_q.push_back(cyc + 1);
            end else begin
                exp_cyc_q.push_back(cyc + 1);
                exp_b_q.push_back(b);
                if (op == 5'b11100) m_halted = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] f3, input logic f7,
                         input logic fl, input logic rs);
        @(negedge clk);
        instr_valid = v; opcode = op; funct3 = f3; funct7_0 = f7; flush = fl; resume = rs;
        #1;
        check("instr_ready", instr_ready, rst_n && !m_halted && (m_busy == 0) && !fl);
        check("md_busy", md_busy, m_busy > 0);
        check("halted", halted, m_halted);
        model_step(v, op, f3, f7, fl, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ctrl_valid) begin
                if (exp_cyc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ctrl_valid: unexpected at cycle %0d bundle %0h", cyc, obs);
                end else begin
                    check("ctrl_cycle", cyc, exp_cyc_q.pop_front());
                    check("bundle", obs, exp_b_q.pop_front());
                end
            end
            if (md_start) begin
                if (start_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL md_start: unexpected at cycle %0d", cyc);
                end else check("md_start_cycle", cyc, start_q.pop_front());
            end
            if (md_abort) begin
                if (abort_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL md_abort: unexpected at cycle %0d", cyc);
                end else check("md_abort_cycle", cyc, abort_q.pop_front());
            end
        end
    end

    logic [4:0] op_tab [11] = '{5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b01101, 5'b00101,
                                5'b11000, 5'b11001, 5'b11011, 5'b00011, 5'b11100};

    initial begin
        logic [4:0] rop;
        logic [18:0] exp_nm;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {instr_ready, ctrl_valid, obs, md_start, md_busy, md_abort, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 5'b00000, 3'b010, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 5'b01100, 3'b000, 1'b1, 1'b0, 1'b0);
        idle(4);
        drive(1'b1, 5'b01100, 3'b100, 1'b1, 1'b0, 1'b0);
        idle(9);
        drive(1'b0, 5'b00000, 3'b000, 1'b0, 1'b1, 1'b0);
        idle(3);
        drive(1'b1, 5'b11100, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 5'b11111, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 5'b01101 + 5'(i), 3'(i), 1'b0, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            rop = ($urandom % 16 < 12) ? op_tab[$urandom % 11] : 5'($urandom);
            drive(($urandom % 4) != 0, rop, 3'($urandom), 1'($urandom), ($urandom % 20) == 0,
                  ($urandom % 4) == 0);
        end
        for (int i = 0; i < 40; i++) drive(1'b0, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b1);
        check("ctrl_queue_drained", exp_cyc_q.size(), 0);
        check("start_queue_drained", start_q.size(), 0);
        check("abort_queue_drained", abort_q.size(), 0);

        drive(1'b1, 5'b01100, 3'b101, 1'b1, 1'b0, 1'b0);
        idle(6);
        @(negedge clk);
        instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs", {instr_ready, ctrl_valid, obs, md_start, md_busy, md_abort, halted}, 32'd0);
        m_busy = 0;
        m_halted = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        drive(1'b1, 5'b00100, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("post_reset_drained", exp_cyc_q.size() + start_q.size() + abort_q.size(), 0);

        @(negedge clk);
        n_instr_valid = 1'b1; n_opcode = 5'b01100; n_funct3 = 3'b100; n_funct7_0 = 1'b1;
        @(negedge clk);
        n_instr_valid = 1'b0;
        exp_nm = ref_decode(5'b01100, 3'b100, 1'b1, 1'b0);
        check("nm_ctrl_valid", n_ctrl_valid, 1'b1);
        check("nm_bundle", n_obs, exp_nm);
        for (int i = 0; i < 4; i++) begin
            check("nm_md_start", {n_md_start, n_md_busy, n_instr_ready}, 3'b001);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_seq_control_unit.md
# rv_seq_control_unit

Registered, stall-aware successor to the single-cycle decoder. Decodes `instr[6:2]` into the datapath control bundle, registers it into the ID/EX boundary, and sequences multi-cycle RV32M operations with a parametrised MUL/DIV latency. Handles FENCE as a NOP and EBREAK as a halt until resumed. It sits between the fetch/ID stage and the execute stage.

## Interface
Parameters:
- `ENABLE_M`, 1: when 0, M-encoded R-type ops decode as ordinary R-type.
- `MUL_CYCLES`, 2: busy cycles for funct3[2]=0 M ops; must be ≥1.
- `DIV_CYCLES`, 32: busy cycles for funct3[2]=1 M ops; must be ≥1.
- `CNT_W`, 6: counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: an instruction is presented.
- `instr_ready` out 1: combinational; equals (state==RUN) && !flush.
- `opcode` in 5: instr[6:2].
- `funct3` in 3: instr[14:12].
- `funct7_0` in 1: instr[25], the M-extension select bit.
- `flush` in 1: synchronous kill.
- `resume` in 1: leaves HALT.
- `ctrl_valid` out 1: the bundle below is valid this cycle.
- Bundle outputs, all registered: `branch`, `mem_read`, `mem_to_reg`, `mem_write`, `alu_src`, `reg_write`, `alu_op[1:0]`, `jal_flag`, `jal_sel[1:0]`, `wb_sel[1:0]`, `r_check`, `md_op`, `md_funct[2:0]`.
- `md_start` out 1: one-cycle pulse when an M op starts.
- `md_busy` out 1: high while state==MD_WAIT.
- `md_abort` out 1: one-cycle pulse when a flush kills an M op.
- `halted` out 1: high while state==HALT.
- `illegal` out 1: registered; high with `ctrl_valid` for an unknown opcode.

## Operation
- FSM states: RUN, MD_WAIT, HALT. Reset state is RUN.
- Accept condition: instr_valid && instr_ready.

Decode per opcode:
- LOAD 00000: mem_read, mem_to_reg, alu_src, reg_write; alu_op=00; wb_sel=10.
- STORE 01000: mem_write, alu_src; alu_op=00.
- OP-IMM 00100: alu_src, reg_write; alu_op=00; wb_sel=10.
- OP 01100: reg_write, r_check; alu_op=10; wb_sel=10.
- LUI 01101: reg_write; wb_sel=11.
- AUIPC 00101: reg_write; wb_sel=00.
- BRANCH 11000: branch; alu_op=01; jal_sel=01.
- JALR 11001: reg_write, jal_flag; jal_sel=10; wb_sel=01.
- JAL 11011: reg_write, jal_flag; jal_sel=11; wb_sel=01.
- FENCE 00011 and EBREAK 11100: all bundle bits 0.
- Any other opcode: all bundle bits 0 and illegal=1.
- Any bit not listed for an opcode is 0.

M op: opcode 01100 && funct7_0 && ENABLE_M.
- Bundle is the OP bundle plus md_op=1 and md_funct=funct3.
- Latency N is DIV_CYCLES if funct3[2]=1, else MUL_CYCLES.

Transitions:
- RUN, accept M op: load counter with N and go to MD_WAIT. md_start=1 in the next cycle. No ctrl_valid in the next cycle.
- RUN, accept EBREAK: go to HALT. The NOP bundle is output with ctrl_valid=1.
- RUN, accept any other opcode: stay in RUN; the bundle is registered with ctrl_valid=1.
- RUN, no accept: ctrl_valid=0 next cycle. Bundle bits hold their last value.
- MD_WAIT: the counter decrements each cycle. When count==1, go to RUN and register the M bundle with ctrl_valid=1.
- HALT: resume goes to RUN. instr_valid is ignored while in HALT.

Flush (highest priority, sampled at the edge):
- ctrl_valid=0 next cycle.
- In MD_WAIT: go to RUN, clear the counter, and pulse md_abort next cycle.
- Flush does not leave HALT.
- flush together with instr_valid: the instruction is not accepted.

Reset:
- Every output resets to 0. The counter resets to 0.
- Reset asserted mid-M-op: returns to RUN without md_abort.

## Timing
- Non-M instruction accepted in cycle t: ctrl_valid in t+1. Back-to-back accepts give ctrl_valid every cycle.
- M op accepted in cycle t:
  - md_start in t+1.
  - md_busy and instr_ready=0 in t+1..t+N.
  - ctrl_valid with the M bundle in t+N+1, the same cycle instr_ready returns to 1.
- EBREAK accepted in cycle t: halted=1 from t+1.
- resume in cycle h: halted=0 and instr_ready=1 in h+1.
- Flush in MD_WAIT in cycle f: md_abort=1 and md_busy=0 in f+1.

## Structure
- Shared package `rv_ctrl_pkg`:
  - opcode constants,
  - alu_op encodings (00 add, 01 branch, 10 R-type),
  - wb_sel encodings (00 AUIPC, 01 PC+4, 10 ALU/mem, 11 LUI),
  - jal_sel encodings,
  - FSM state typedef.
- Sub-module `rv_ctrl_decode`: purely combinational decode of opcode, funct3 and funct7_0 into the bundle, m_op and illegal. The top level holds the FSM, counter and output registers.

## Test plan
- Reset, then present LW (00000): ctrl_valid=1 in t+1 with mem_read=mem_to_reg=alu_src=reg_write=1, wb_sel=10, and every other bundle bit 0.
- MUL (01100, funct7_0=1, funct3=000) with MUL_CYCLES=2: md_start in t+1, instr_ready=0 in t+1..t+2, ctrl_valid with md_op=1 and md_funct=000 in t+3.
- DIV (funct3=100) with DIV_CYCLES=32 and flush in t+10: md_abort in t+11, ctrl_valid never asserts for the DIV, instr_ready=1 in t+11.
- EBREAK, then instr_valid held high for 5 cycles, then resume: halted=1 and no accepts during the hold; resume in h gives instr_ready=1 in h+1.
- Opcode 11111: ctrl_valid=1 and illegal=1 with an all-zero bundle. ENABLE_M=0 with funct7_0=1: a plain R-type bundle in t+1 and md_start never pulses.
- rst_n asserted in MD_WAIT mid-DIV: all outputs 0 immediately; after release, state is RUN and md_abort stays 0.
